// File: rtl/cnt_trk_pkg.sv
// Shared constants and record layout helpers for the step-counter wrap tracker.
// A record is {kind, tag, value}, with value in the least-significant bits.
package cnt_trk_pkg;

    localparam logic EVT_WRAP = 1'b0;
    localparam logic EVT_ERR  = 1'b1;
    localparam int   VAL_LSB  = 0;

    function automatic int rec_w(input int tag_w, input int width);
        return 1 + tag_w + width;
    endfunction

    function automatic int tag_lsb(input int width);
        return width;
    endfunction

    function automatic int kind_pos(input int tag_w, input int width);
        return tag_w + width;
    endfunction

endpackage

// File: rtl/cnt_trk_fifo.sv
// In-order event FIFO with registered storage and drop-on-full semantics.
// The head reads as zero while empty so the output never exposes stale storage.
module cnt_trk_fifo
    import cnt_trk_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 13
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DATA_W-1:0]        head,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cnt_wrap_tracker.sv
// Monitors a free-running step counter: checks each sample against prev+1,
// counts wrap-arounds and queues wrap / step-error records for a trace drain.
module cnt_wrap_tracker
    import cnt_trk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [WIDTH-1:0]          cnt_in,
    input  logic                      cnt_vld,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [TAG_W+WIDTH:0]      evt_data,
    output logic [TAG_W-1:0]          wrap_cnt,
    output logic [$clog2(DEPTH):0]    evt_level,
    output logic                      overflow
);

    localparam int REC_W    = rec_w(TAG_W, WIDTH);
    localparam int TAG_LSB  = tag_lsb(WIDTH);
    localparam int KIND_POS = kind_pos(TAG_W, WIDTH);

    logic              armed;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  prev_inc;
    logic              evt_push;
    logic              evt_wrap;
    logic              evt_pop;
    logic [REC_W-1:0]  evt_rec;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;

    assign prev_inc = prev + WIDTH'(1);
    assign evt_pop  = evt_valid & evt_ready;

    // Wrap takes priority; any other non-increment (including a hold) is an error.
    always_comb begin
        evt_push = 1'b0;
        evt_wrap = 1'b0;
        evt_rec  = '0;
        evt_rec[TAG_LSB +: TAG_W] = wrap_cnt;
        if (cnt_vld && armed) begin
            if (prev == '1 && cnt_in == '0) begin
                evt_push          = 1'b1;
                evt_wrap          = 1'b1;
                evt_rec[KIND_POS] = EVT_WRAP;
            end else if (cnt_in != prev_inc) begin
                evt_push                  = 1'b1;
                evt_rec[KIND_POS]         = EVT_ERR;
                evt_rec[VAL_LSB +: WIDTH] = cnt_in;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            armed    <= 1'b0;
            prev     <= '0;
            wrap_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (cnt_vld) begin
                armed <= 1'b1;
                prev  <= cnt_in;
            end
            if (evt_wrap)  wrap_cnt <= wrap_cnt + 1'b1;
            if (fifo_drop) overflow <= 1'b1;
        end
    end

    cnt_trk_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (REC_W)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (evt_push),
        .push_data (evt_rec),
        .pop       (evt_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (evt_level),
        .head      (evt_data),
        .drop      (fifo_drop)
    );

    assign evt_valid = ~fifo_empty;

    // A dropped record can only come from a full queue.
    always_comb begin
        assert (fifo_full || !fifo_drop);
    end

endmodule

// File: doc/cnt_wrap_tracker.md
Name: cnt_wrap_tracker

Overview:
Downstream monitor for the 4-bit free-running step counter. It samples the counter value on a qualifying strobe and checks every step against prev+1 mod 2^WIDTH. It counts wrap-arounds and queues wrap and step-error event records in a small FIFO. A valid/ready interface drains the queue to the debug/trace collector.

Parameters:
WIDTH, 4, counter width in bits
DEPTH, 4, event FIFO entries; power of 2, >= 2
TAG_W, 8, wrap-index width (wraps mod 2^TAG_W)

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
cnt_in  in  WIDTH  counter value being observed
cnt_vld  in  1  sample strobe; cnt_in is checked only when high
evt_valid  out  1  head-of-FIFO record available
evt_ready  in  1  consumer accepts record when evt_valid & evt_ready
evt_data  out  1+TAG_W+WIDTH  {kind, tag, value}; kind 0 = wrap, 1 = step error
wrap_cnt  out  TAG_W  number of wraps seen, mod 2^TAG_W
evt_level  out  log2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; an event was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release):
  - evt_valid=0, evt_data=0, wrap_cnt=0, evt_level=0, overflow=0
  - FIFO emptied; armed=0; prev=0
- Arming:
  - The first cnt_vld sample after reset is not checked.
  - It only loads prev<=cnt_in and sets armed=1. No event is generated.
- Check, on each cnt_vld sample while armed, in priority order:
  - prev==all-ones & cnt_in==0: wrap event {0, wrap_cnt, 0}, then wrap_cnt<=wrap_cnt+1 (wraps silently at 2^TAG_W). The tag carries the pre-increment value.
  - Otherwise, if cnt_in != prev+1 (WIDTH-bit modular add): error event {1, wrap_cnt, cnt_in}. A held value (cnt_in==prev) is an error. A jump to 0 from a non-all-ones value is an error, not a wrap.
  - Otherwise: no event.
  - Every sample, event or not, sets prev<=cnt_in (resynchronises after an error).
- cnt_vld low: no state change except FIFO pops.
- Latency: an event detected at edge N is written at edge N. If the FIFO was empty, evt_valid=1 and evt_data=record from edge N onward. There is no combinational bypass from cnt_in to evt_data.
- FIFO: in-order, registered head (evt_data driven from storage).
  - Pop when evt_valid & evt_ready. evt_data must hold stable while evt_valid & !evt_ready.
  - Push & pop in the same cycle: both happen and level is unchanged. This holds when full, so no drop occurs.
  - Push & pop when empty is impossible (evt_valid=0).
  - Push when full without pop: record dropped, overflow<=1 (held until RST), level stays DEPTH. wrap_cnt still increments on a dropped wrap.
  - Read/write pointers wrap mod DEPTH. Level is computed from pointers with an extra MSB.
- Reset mid-operation: all queued records are discarded immediately (evt_valid falls asynchronously). The next sample re-arms without a check.

Decomposition:
- Package cnt_trk_pkg holds:
  - EVT_WRAP=1'b0 and EVT_ERR=1'b1 constants
  - the record-width localparam expression 1+TAG_W+WIDTH
  - field offsets for kind/tag/value
- One sub-module, cnt_trk_fifo: parameterised DEPTH/data-width synchronous FIFO. It has push/pop/full/empty/level, uses the same CLK/RST, and has drop-on-full semantics with an overflow pulse to the parent.
- Checker logic and wrap counter stay in cnt_wrap_tracker.

Test Plan:
- Reset check: RST high 3 cycles, evt_ready=1 -> all outputs 0. The first sample cnt_in=7 generates no event.
- Clean wrap: samples 0,1,...,15,0 with evt_ready=1 -> exactly one record 0x000 (kind 0, tag 0x00, value 0), then wrap_cnt=1. A second full cycle produces record tag 0x01 and wrap_cnt=2.
- Step error: samples 2,3,5,6 -> one record kind 1, tag=wrap_cnt, value 5 (evt_data=0x1005 when wrap_cnt=0). 5->6 produces no further event. Repeated sample 6,6 produces an error with value 6.
- Backpressure/overflow: evt_ready=0, force 5 error events with DEPTH=4 -> evt_level=4, overflow=1. Draining then yields the first 4 records in order, evt_level steps 4,3,2,1,0 and overflow stays 1.
- Full simultaneous push/pop: FIFO full, evt_ready=1 and a new event in the same cycle -> level stays 4, no overflow, new record appears last.
- Reset mid-operation: 2 records queued, assert RST between edges -> evt_valid=0 before the next edge. After release, sample 9 is not checked and sample 10 generates no event.
